// File: rtl/bd_sync_pkg.sv
// Shared types and sizing helpers for the two-phase bundled-data synchronous endpoints.
// Holds the receiver FSM encoding and the settle-counter width rule.
package bd_sync_pkg;

    localparam int DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } rx_state_e;

    // Settle counter must hold SETTLE_CYCLES; keep at least one bit so SETTLE_CYCLES=0 still builds.
    function automatic int settle_cnt_width(input int settle_cycles);
        int w;
        w = $clog2(settle_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bd2ph_sync_receiver_if.sv
// Two-phase request/ack channel plus clocked valid/ready output of the receiver.
// slave = the receiver's view, master = the sender/consumer environment.
interface bd2ph_sync_receiver_if #(
    parameter int DW = bd_sync_pkg::DEFAULT_DW
) ();
    logic          inR;
    logic [DW-1:0] in_data;
    logic          outA;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport slave (
        input  inR,
        input  in_data,
        input  m_ready,
        output outA,
        output m_valid,
        output m_data
    );

    modport master (
        output inR,
        output in_data,
        output m_ready,
        input  outA,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/sync_nff.sv
// N-stage single-bit synchroniser, synchronous active-high reset to 0.
// Latency: N clock edges from d to q; no flow control.
module sync_nff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/bd2ph_sync_receiver.sv
// Receives two-phase bundled data: sync inR, wait SETTLE_CYCLES, capture, offer on valid/ready, toggle outA.
// m_valid after edge SYNC_STAGES+SETTLE_CYCLES+1; holds word and withholds outA while m_ready is low.
module bd2ph_sync_receiver
    import bd_sync_pkg::*;
#(
    parameter int DW            = DEFAULT_DW,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bd2ph_sync_receiver_if.slave   bus,
    output logic                   busy,
    output logic                   proto_err
);

    localparam int CNT_W = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

    rx_state_e      state_q, state_d;
    logic           req_phase_q, req_phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           out_a_q, out_a_d;
    logic           m_valid_q, m_valid_d;
    logic [DW-1:0]  m_data_q, m_data_d;
    logic           proto_err_q, proto_err_d;
    logic           sreq;
    logic           req_pending;

    sync_nff #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.inR),
        .q   (sreq)
    );

    assign req_pending = (sreq != req_phase_q);

    always_comb begin
        state_d     = state_q;
        req_phase_d = req_phase_q;
        cnt_d       = cnt_q;
        out_a_d     = out_a_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: begin
                if (req_pending) begin
                    req_phase_d = sreq;
                    cnt_d       = CNT_INIT;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                if (req_pending) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    m_data_d  = bus.in_data;
                    m_valid_d = 1'b1;
                    state_d   = VALID;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            VALID: begin
                // An early extra transition is only flagged; it is served from IDLE afterwards.
                if (req_pending) begin
                    proto_err_d = 1'b1;
                end
                if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    out_a_d   = ~out_a_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_phase_q <= 1'b0;
            cnt_q       <= '0;
            out_a_q     <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_phase_q <= req_phase_d;
            cnt_q       <= cnt_d;
            out_a_q     <= out_a_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.outA    = out_a_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign busy        = (state_q != IDLE);
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_bd2ph_sync_receiver.sv
// Directed bench: cycle table for transfer/back-pressure, then streaming, latency, protocol and reset sequences.
module tb_bd2ph_sync_receiver;

    logic        clk;
    logic        rst;
    logic        in_r;
    logic [31:0] in_data;
    logic        m_ready;

    int total;
    int bad;

    bd2ph_sync_receiver_if #(.DW(32)) bus0  ();
    bd2ph_sync_receiver_if #(.DW(32)) bus_s0 ();
    bd2ph_sync_receiver_if #(.DW(32)) bus_s5 ();

    assign bus0.inR     = in_r;
    assign bus0.in_data = in_data;
    assign bus0.m_ready = m_ready;
    assign bus_s0.inR     = in_r;
    assign bus_s0.in_data = in_data;
    assign bus_s0.m_ready = m_ready;
    assign bus_s5.inR     = in_r;
    assign bus_s5.in_data = in_data;
    assign bus_s5.m_ready = m_ready;

    logic busy0, perr0, busy_s0, perr_s0, busy_s5, perr_s5;

    bd2ph_sync_receiver #(.DW(32), .SYNC_STAGES(2), .SETTLE_CYCLES(1)) dut (
        .clk (clk), .rst (rst), .bus (bus0), .busy (busy0), .proto_err (perr0)
    );
    bd2ph_sync_receiver #(.DW(32), .SYNC_STAGES(2), .SETTLE_CYCLES(0)) dut_s0 (
        .clk (clk), .rst (rst), .bus (bus_s0), .busy (busy_s0), .proto_err (perr_s0)
    );
    bd2ph_sync_receiver #(.DW(32), .SYNC_STAGES(2), .SETTLE_CYCLES(5)) dut_s5 (
        .clk (clk), .rst (rst), .bus (bus_s5), .busy (busy_s5), .proto_err (perr_s5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        in_r;
        logic        m_ready;
        logic [31:0] in_data;
        logic        exp_valid;
        logic        exp_outa;
        logic        exp_busy;
        logic        exp_perr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic req, input logic rdy, input logic [31:0] d,
                       input logic v, input logic a, input logic b, input logic pe,
                       input logic [31:0] md);
        vec_t x;
        x.rst = r; x.in_r = req; x.m_ready = rdy; x.in_data = d;
        x.exp_valid = v; x.exp_outa = a; x.exp_busy = b; x.exp_perr = pe; x.exp_data = md;
        vecs.push_back(x);
    endtask

    // Advance one rising edge and settle on the following falling edge for sampling.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (bus0.m_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        in_r = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int lat0, lat1, lat5, words, spurious;
        logic perr_first;
        logic exp_a;

        total = 0;
        bad = 0;
        rst = 1'b1;
        in_r = 1'b0;
        in_data = 32'h0;
        m_ready = 1'b0;
        @(negedge clk);

        // rst, inR, m_ready, in_data | valid, outA, busy, proto_err, m_data
        add(1, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0);
        add(1, 0, 1, 32'h0,         0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 32'hA5A5_1234, 0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 32'hA5A5_1234, 0, 0, 0, 0, 32'h0);
        add(0, 1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 32'h0);
        add(0, 1, 1, 32'hA5A5_1234, 0, 0, 1, 0, 32'h0);
        add(0, 1, 1, 32'hA5A5_1234, 1, 0, 1, 0, 32'hA5A5_1234);
        add(0, 1, 1, 32'hA5A5_1234, 0, 1, 0, 0, 32'hA5A5_1234);
        add(0, 1, 1, 32'hA5A5_1234, 0, 1, 0, 0, 32'hA5A5_1234);
        add(0, 0, 0, 32'h5A5A_0F0F, 0, 1, 0, 0, 32'hA5A5_1234);
        add(0, 0, 0, 32'h5A5A_0F0F, 0, 1, 0, 0, 32'hA5A5_1234);
        add(0, 0, 0, 32'h5A5A_0F0F, 0, 1, 1, 0, 32'hA5A5_1234);
        add(0, 0, 0, 32'h5A5A_0F0F, 0, 1, 1, 0, 32'hA5A5_1234);
        add(0, 0, 0, 32'h5A5A_0F0F, 1, 1, 1, 0, 32'h5A5A_0F0F);
        for (int i = 0; i < 10; i++) begin
            add(0, 0, 0, 32'hDEAD_BEEF, 1, 1, 1, 0, 32'h5A5A_0F0F);
        end
        add(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h5A5A_0F0F);

        for (int i = 0; i < vecs.size(); i++) begin
            rst     = vecs[i].rst;
            in_r    = vecs[i].in_r;
            m_ready = vecs[i].m_ready;
            in_data = vecs[i].in_data;
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, bus0.m_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_outA", i),  {31'd0, bus0.outA},    {31'd0, vecs[i].exp_outa});
            check($sformatf("vec%0d_busy", i),  {31'd0, busy0},        {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_perr", i),  {31'd0, perr0},        {31'd0, vecs[i].exp_perr});
            check($sformatf("vec%0d_data", i),  bus0.m_data,           vecs[i].exp_data);
        end

        // Streaming: eight words, next toggle only after the previous outA toggle.
        m_ready = 1'b1;
        exp_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(i);
            in_r = ~in_r;
            wait_valid(20, ok);
            check($sformatf("stream%0d_valid_seen", i), {31'd0, ok}, 32'd1);
            check($sformatf("stream%0d_data", i), bus0.m_data, 32'(i));
            tick();
            exp_a = ~exp_a;
            check($sformatf("stream%0d_outA", i), {31'd0, bus0.outA}, {31'd0, exp_a});
        end
        check("stream_outA_end", {31'd0, bus0.outA}, 32'd0);
        check("stream_perr", {31'd0, perr0}, 32'd0);

        // Latency for SETTLE_CYCLES = 0, 1, 5 from the edge that first samples inR.
        do_reset();
        m_ready = 1'b1;
        in_data = 32'h1357_9BDF;
        in_r = 1'b1;
        lat0 = -1; lat1 = -1; lat5 = -1;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (bus_s0.m_valid === 1'b1 && lat0 < 0) lat0 = e;
            if (bus0.m_valid   === 1'b1 && lat1 < 0) lat1 = e;
            if (bus_s5.m_valid === 1'b1 && lat5 < 0) begin
                lat5 = e;
                check("lat_s5_data", bus_s5.m_data, 32'h1357_9BDF);
            end
        end
        check("lat_settle0", 32'(lat0), 32'd3);
        check("lat_settle1", 32'(lat1), 32'd4);
        check("lat_settle5", 32'(lat5), 32'd8);
        check("lat_s5_outA", {31'd0, bus_s5.outA}, 32'd1);

        // Two inR transitions one cycle apart.
        do_reset();
        m_ready = 1'b1;
        in_data = 32'h0BAD_F00D;
        in_r = 1'b1;
        tick();
        in_r = 1'b0;
        words = 0;
        perr_first = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus0.m_valid === 1'b1) begin
                words++;
                if (words == 1) perr_first = perr0;
            end
        end
        check("perr_during_first", {31'd0, perr_first}, 32'd1);
        check("perr_words", 32'(words), 32'd2);
        check("perr_outA_end", {31'd0, bus0.outA}, 32'd0);
        check("perr_sticky", {31'd0, perr0}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perr_cleared_by_rst", {31'd0, perr0}, 32'd0);

        // Reset while a word is waiting in VALID.
        m_ready = 1'b0;
        in_data = 32'hCAFE_0001;
        in_r = 1'b1;
        wait_valid(20, ok);
        check("midrst_valid_seen", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        in_r = 1'b0;
        tick();
        check("midrst_valid", {31'd0, bus0.m_valid}, 32'd0);
        check("midrst_outA", {31'd0, bus0.outA}, 32'd0);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        spurious = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus0.m_valid !== 1'b0 || bus0.outA !== 1'b0 || busy0 !== 1'b0) spurious++;
        end
        check("midrst_no_spurious", 32'(spurious), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
